nibble_serial_add_ctrl: RTL

//   Sequences one 4-bit ripple-carry adder slice (s = a + b + cin) across multi-nibble operands.

---
 rtl/nibble_serial_add_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Multi-nibble add/subtract sequenced through a single 4-bit adder slice, LSB nibble first.
// Latency: start accepted at edge k -> done pulses in the cycle after edge k+NIBBLES.
// Backpressure: none; start is ignored while busy, and is accepted in IDLE or DONE (back-to-back).
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic           carry;
    logic [IW-1:0]  idx;

    logic [3:0]     a_nib;
    logic [3:0]     b_nib;
    logic [4:0]     sum;
    logic           c3;
    logic           last;

    // The shared 4-bit slice: current nibble of A and (possibly inverted) B plus chained carry.
    // Carry into bit 3 is recovered from the bit-3 sum, avoiding a second partial adder.
    always_comb begin
        a_nib = a_reg[idx*4 +: 4];
        b_nib = b_reg[idx*4 +: 4];
        sum   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
        c3    = a_nib[3] ^ b_nib[3] ^ sum[3];
        last  = (idx == IW'(NIBBLES - 1));
    end

    // Control FSM with registered outputs; subtraction is A + ~B + 1 via the initial carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg  <= op_a;
                        b_reg  <= sub ? ~op_b : op_b;
                        carry  <= sub;
                        idx    <= '0;
                        result <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    result[idx*4 +: 4] <= sum[3:0];
                    carry              <= sum[4];
                    if (last) begin
                        cout  <= sum[4];
                        ovf   <= c3 ^ sum[4];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
